// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared funct3 encodings, scheduler states and decode helper
package cmp_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } cmp_state_t;

  function automatic logic f3_illegal(input logic [2:0] funct3);
    return !(funct3 inside {F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU});
  endfunction

endpackage

// File: rtl/cu.sv
// rtl/cu.sv - shared comparison unit: equality or signed/unsigned less-than, optionally inverted
module cu #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_lt,
  input  logic             i_invert,
  input  logic             i_unsigned,
  output logic             o_result
);

  logic w_eq;
  logic w_lt_s;
  logic w_lt_u;
  logic w_raw;

  assign w_eq     = (i_a == i_b);
  assign w_lt_u   = (i_a < i_b);
  assign w_lt_s   = ($signed(i_a) < $signed(i_b));
  assign w_raw    = i_lt ? (i_unsigned ? w_lt_u : w_lt_s) : w_eq;
  assign o_result = w_raw ^ i_invert;

endmodule

// File: rtl/cmp_sched.sv
// rtl/cmp_sched.sv - two-port scheduler for the shared comparison unit
// CMP_SCHED_RR_EN selects round-robin tie-breaking; otherwise port 0 has fixed priority.
module cmp_sched
  import cmp_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req0_ra,
  input  logic [WIDTH-1:0] req0_rb,
  input  logic [2:0]       req0_funct3,
  input  logic [WIDTH-1:0] req1_ra,
  input  logic [WIDTH-1:0] req1_rb,
  input  logic [2:0]       req1_funct3,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic             rsp_out,
  output logic             rsp_err,
  output logic             busy
);

  cmp_state_t       r_state;
  logic             r_gnt;
  logic [WIDTH-1:0] r_ra;
  logic [WIDTH-1:0] r_rb;
  logic [2:0]       r_f3;
  logic             r_err;
  logic             r_res;
  logic             w_port;
  logic [2:0]       w_f3;
  logic             w_cu_res;
`ifdef CMP_SCHED_RR_EN
  logic             r_last;
`endif

  // Arbiter: w_port is only meaningful when some request is valid.
  always_comb begin
    w_port = req_valid[1] & ~req_valid[0];
`ifdef CMP_SCHED_RR_EN
    if (req_valid == 2'b11) w_port = ~r_last;
`endif
  end

  assign w_f3      = w_port ? req1_funct3 : req0_funct3;
  assign req_ready = (r_state == IDLE && !flush && |req_valid) ?
                     (w_port ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_valid = (r_state == RESP) ? (r_gnt ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_out   = (r_state == RESP) & r_res;
  assign rsp_err   = (r_state == RESP) & r_err;
  assign busy      = (r_state != IDLE);

  cu #(.WIDTH(WIDTH)) u_cu (
    .i_a        (r_ra),
    .i_b        (r_rb),
    .i_lt       (r_f3[2]),
    .i_invert   (r_f3[0]),
    .i_unsigned (r_f3[1]),
    .o_result   (w_cu_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_gnt   <= 1'b0;
      r_ra    <= '0;
      r_rb    <= '0;
      r_f3    <= '0;
      r_err   <= 1'b0;
      r_res   <= 1'b0;
`ifdef CMP_SCHED_RR_EN
      r_last  <= 1'b1;
`endif
    end else if (flush) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (|req_valid) begin
            r_state <= EVAL;
            r_gnt   <= w_port;
            r_ra    <= w_port ? req1_ra : req0_ra;
            r_rb    <= w_port ? req1_rb : req0_rb;
            r_f3    <= w_f3;
            r_err   <= f3_illegal(w_f3);
`ifdef CMP_SCHED_RR_EN
            r_last  <= w_port;
`endif
          end
        end
        EVAL: begin
          // Illegal encodings still flow through cu; their result is forced low.
          r_res   <= w_cu_res & ~r_err;
          r_state <= RESP;
        end
        RESP: begin
          if (rsp_ready[r_gnt]) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
